mainbus_reg_arbiter: RTL and testbench

//  Shares the 8-bit general-purpose/constant register write path on the main bus

---
 rtl/mainbus_reg_arbiter_pkg.sv | 10 +
 rtl/mainbus_reg_arbiter_if.sv | 32 +++
 rtl/mainbus_reg_arbiter_rr_arb2.sv | 31 +++
 rtl/mainbus_reg_arbiter.sv | 104 ++++++++++
 tb/tb_mainbus_reg_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mainbus_reg_arbiter_pkg.sv
// Shared types and constants for the main-bus register write arbiter.
package mainbus_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int NUM_REGS_DEF = 4;
  localparam int SEL_W_DEF    = 2;
endpackage

// File: rtl/mainbus_reg_arbiter_if.sv
// Requester handshakes plus register-side strobes/bus of the write arbiter.
interface mainbus_reg_arbiter_if
  import mainbus_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int SEL_W    = SEL_W_DEF
);
  logic                pa_valid;
  logic                pa_ready;
  logic [SEL_W-1:0]    pa_sel;
  logic [7:0]          pa_data;
  logic                pb_valid;
  logic                pb_ready;
  logic [SEL_W-1:0]    pb_sel;
  logic [7:0]          pb_data;
  logic                pb_lock;
  logic [NUM_REGS-1:0] reg_load_n;
  logic [7:0]          bus_out;
  logic                bus_owner;
  logic                sel_err;
  logic [7:0]          stall_cnt;

  modport master (
    output pa_valid, pa_sel, pa_data, pb_valid, pb_sel, pb_data, pb_lock,
    input  pa_ready, pb_ready, reg_load_n, bus_out, bus_owner, sel_err, stall_cnt
  );

  modport slave (
    input  pa_valid, pa_sel, pa_data, pb_valid, pb_sel, pb_data, pb_lock,
    output pa_ready, pb_ready, reg_load_n, bus_out, bus_owner, sel_err, stall_cnt
  );
endinterface

// File: rtl/mainbus_reg_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; lock pins the grant on B while B is requesting.
module rr_arb2
  import mainbus_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic lock,
  input  logic upd,
  input  logic upd_port,
  output logic gnt_vld,
  output logic gnt,
  output logic held
);
  logic last;

  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)      last <= PORT_B;
    else if (upd) last <= upd_port;
  end

  always_comb begin
    held    = lock && req_b;
    gnt_vld = req_a || req_b;
    if (held)                gnt = PORT_B;
    else if (req_a && req_b) gnt = ~last;
    else                     gnt = req_b ? PORT_B : PORT_A;
  end
endmodule

// File: rtl/mainbus_reg_arbiter.sv
// Arbitrates two writers onto the register load path with a turnaround cycle
// on owner change; strobes, bus data and owner are registered.
module mainbus_reg_arbiter
  import mainbus_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int SEL_W    = SEL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mainbus_reg_arbiter_if.slave bus
);
  state_t              state, nxt;
  logic                ra, rb, xfer, xport;
  logic                gnt_vld, gnt, held;
  logic                own_v, oth_v, sel_ok, stall_evt;
  logic [SEL_W-1:0]    sel;
  logic [7:0]          data;
  logic [NUM_REGS-1:0] strobe, load_n;
  logic [7:0]          bus_q, stall;
  logic                owner, err;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_a    (bus.pa_valid),
    .req_b    (bus.pb_valid),
    .lock     (bus.pb_lock && owner == PORT_B && state == DRIVE),
    .upd      (xfer),
    .upd_port (xport),
    .gnt_vld  (gnt_vld),
    .gnt      (gnt),
    .held     (held)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt   = state;
    ra    = 1'b0;
    rb    = 1'b0;
    own_v = (owner == PORT_B) ? bus.pb_valid : bus.pa_valid;
    oth_v = (owner == PORT_B) ? bus.pa_valid : bus.pb_valid;
    if (!rst) begin
      case (state)
        IDLE: if (gnt_vld) begin
          ra  = (gnt == PORT_A);
          rb  = (gnt == PORT_B);
          nxt = DRIVE;
        end
        // A waiting non-owner forces a turnaround unless B holds the lock.
        DRIVE: begin
          if (oth_v && !held) nxt = TURN;
          else if (own_v) begin
            ra = (owner == PORT_A);
            rb = (owner == PORT_B);
          end else nxt = IDLE;
        end
        TURN:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  assign xfer      = ra || rb;
  assign xport     = rb;
  assign sel       = xport ? bus.pb_sel : bus.pa_sel;
  assign data      = xport ? bus.pb_data : bus.pa_data;
  assign sel_ok    = int'(sel) < NUM_REGS;
  assign stall_evt = (bus.pa_valid && !ra) || (bus.pb_valid && !rb);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) strobe[i] = (int'(sel) == i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_n <= '1;
      bus_q  <= '0;
      owner  <= PORT_A;
      err    <= 1'b0;
      stall  <= '0;
    end else begin
      load_n <= xfer ? ~strobe : '1;
      err    <= xfer && !sel_ok;
      if (xfer) begin
        bus_q <= data;
        owner <= xport;
      end
      if (stall_evt && stall != 8'hFF) stall <= stall + 8'd1;
    end
  end

  assign bus.pa_ready   = ra;
  assign bus.pb_ready   = rb;
  assign bus.reg_load_n = load_n;
  assign bus.bus_out    = bus_q;
  assign bus.bus_owner  = owner;
  assign bus.sel_err    = err;
  assign bus.stall_cnt  = stall;
endmodule

// File: tb/tb_mainbus_reg_arbiter.sv
// Bench for mainbus_reg_arbiter: directed vector table, corner sequences and a
// random run checked against a cycle-level reference model (4- and 3-reg builds).
module tb_mainbus_reg_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       pa_valid, pb_valid, pb_lock;
  logic [1:0] pa_sel, pb_sel;
  logic [7:0] pa_data, pb_data;

  mainbus_reg_arbiter_if #(.NUM_REGS(4), .SEL_W(2)) b4 ();
  mainbus_reg_arbiter_if #(.NUM_REGS(3), .SEL_W(2)) b3 ();

  mainbus_reg_arbiter #(.NUM_REGS(4), .SEL_W(2)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  mainbus_reg_arbiter #(.NUM_REGS(3), .SEL_W(2)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  assign b4.pa_valid = pa_valid;  assign b3.pa_valid = pa_valid;
  assign b4.pa_sel   = pa_sel;    assign b3.pa_sel   = pa_sel;
  assign b4.pa_data  = pa_data;   assign b3.pa_data  = pa_data;
  assign b4.pb_valid = pb_valid;  assign b3.pb_valid = pb_valid;
  assign b4.pb_sel   = pb_sel;    assign b3.pb_sel   = pb_sel;
  assign b4.pb_data  = pb_data;   assign b3.pb_data  = pb_data;
  assign b4.pb_lock  = pb_lock;   assign b3.pb_lock  = pb_lock;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: busy = a transfer happened last cycle, dead = turnaround cycle.
  bit       m_busy, m_dead, m_owner, m_last, m_ra, m_rb, m_turn, m_err3;
  bit [7:0] m_bus;
  int       m_stall;
  bit [3:0] m_ln4;
  bit [2:0] m_ln3;
  logic     s_ra, s_rb;

  task automatic model_reset();
    m_busy = 0; m_dead = 0; m_owner = 0; m_last = 1; m_err3 = 0;
    m_bus = 0; m_stall = 0; m_ln4 = 4'hF; m_ln3 = 3'h7;
  endtask

  task automatic model_ready();
    bit ov, xv;
    m_ra = 0; m_rb = 0; m_turn = 0;
    if (rst || m_dead) return;
    if (!m_busy) begin
      if (pa_valid && pb_valid) begin
        if (m_last) m_ra = 1; else m_rb = 1;
      end else begin
        m_ra = pa_valid; m_rb = pb_valid;
      end
    end else begin
      ov = m_owner ? pb_valid : pa_valid;
      xv = m_owner ? pa_valid : pb_valid;
      if (xv && !(m_owner && pb_lock && pb_valid)) m_turn = 1;
      else if (ov) begin m_ra = !m_owner; m_rb = m_owner; end
    end
  endtask

  task automatic model_edge();
    bit [1:0] s;
    if (rst) begin model_reset(); return; end
    if (((pa_valid && !m_ra) || (pb_valid && !m_rb)) && m_stall < 255) m_stall++;
    m_ln4 = 4'hF; m_ln3 = 3'h7; m_err3 = 0;
    if (m_ra || m_rb) begin
      s       = m_rb ? pb_sel : pa_sel;
      m_bus   = m_rb ? pb_data : pa_data;
      m_owner = m_rb;
      m_last  = m_rb;
      m_ln4   = ~(4'b0001 << s);
      if (s < 3) m_ln3 = ~(3'b001 << s);
      else       m_err3 = 1;
      m_busy = 1; m_dead = 0;
    end else begin
      m_dead = m_turn; m_busy = 0;
    end
  endtask

  task automatic set_in(input bit r, input bit av, input bit [1:0] as, input bit [7:0] ad,
                        input bit bv, input bit [1:0] bs, input bit [7:0] bd, input bit lk);
    rst = r; pa_valid = av; pa_sel = as; pa_data = ad;
    pb_valid = bv; pb_sel = bs; pb_data = bd; pb_lock = lk;
  endtask

  // Inputs are already applied; samples readys, clocks once, then outputs settle.
  task automatic cycle(input bit use_model);
    #1;
    model_ready();
    s_ra = b4.pa_ready; s_rb = b4.pb_ready;
    if (use_model) begin
      chk("rnd.pa_ready",  b4.pa_ready, m_ra);
      chk("rnd.pb_ready",  b4.pb_ready, m_rb);
      chk("rnd.pa_ready3", b3.pa_ready, m_ra);
      chk("rnd.pb_ready3", b3.pb_ready, m_rb);
      chk("rnd.one_ready", b4.pa_ready & b4.pb_ready, 0);
    end
    @(posedge clk);
    model_edge();
    #1;
    if (use_model) begin
      chk("rnd.load_n4",   b4.reg_load_n, m_ln4);
      chk("rnd.load_n3",   b3.reg_load_n, m_ln3);
      chk("rnd.bus_out",   b4.bus_out,    m_bus);
      chk("rnd.bus_out3",  b3.bus_out,    m_bus);
      chk("rnd.owner",     b4.bus_owner,  m_owner);
      chk("rnd.sel_err4",  b4.sel_err,    0);
      chk("rnd.sel_err3",  b3.sel_err,    m_err3);
      chk("rnd.stall",     b4.stall_cnt,  m_stall);
      chk("rnd.stall3",    b3.stall_cnt,  m_stall);
    end
  endtask

  typedef struct {
    logic rst, pav; logic [1:0] pas; logic [7:0] pad;
    logic pbv; logic [1:0] pbs; logic [7:0] pbd; logic lk;
    logic ra, rb; logic [3:0] ln; logic [7:0] bus; logic own; logic [7:0] stall;
  } vec_t;

  localparam int NV = 22;
  vec_t tv [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit a_seen;
    //        rst av as pad   bv bs pbd   lk  ra rb ln    bus   own stall
    tv[0]  = '{1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4'hF, 8'h00, 0, 0};
    tv[1]  = '{1, 1, 2, 8'h5A, 0, 0, 8'h00, 0, 0, 0, 4'hF, 8'h00, 0, 0};
    tv[2]  = '{0, 1, 2, 8'h5A, 0, 0, 8'h00, 0, 1, 0, 4'hB, 8'h5A, 0, 0};
    tv[3]  = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4'hF, 8'h5A, 0, 0};
    tv[4]  = '{1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4'hF, 8'h00, 0, 0};
    tv[5]  = '{0, 1, 1, 8'h11, 1, 3, 8'h22, 0, 1, 0, 4'hD, 8'h11, 0, 1};
    tv[6]  = '{0, 1, 1, 8'h11, 1, 3, 8'h22, 0, 0, 0, 4'hF, 8'h11, 0, 2};
    tv[7]  = '{0, 1, 1, 8'h11, 1, 3, 8'h22, 0, 0, 0, 4'hF, 8'h11, 0, 3};
    tv[8]  = '{0, 1, 1, 8'h11, 1, 3, 8'h22, 0, 0, 1, 4'h7, 8'h22, 1, 4};
    tv[9]  = '{0, 1, 0, 8'h33, 0, 0, 8'h00, 0, 0, 0, 4'hF, 8'h22, 1, 5};
    tv[10] = '{0, 1, 0, 8'h33, 0, 0, 8'h00, 0, 0, 0, 4'hF, 8'h22, 1, 6};
    tv[11] = '{0, 1, 0, 8'h33, 0, 0, 8'h00, 0, 1, 0, 4'hE, 8'h33, 0, 6};
    tv[12] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4'hF, 8'h33, 0, 6};
    tv[13] = '{1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4'hF, 8'h00, 0, 0};
    tv[14] = '{0, 0, 0, 8'h00, 1, 0, 8'h10, 1, 0, 1, 4'hE, 8'h10, 1, 0};
    tv[15] = '{0, 1, 2, 8'hAA, 1, 1, 8'h11, 1, 0, 1, 4'hD, 8'h11, 1, 1};
    tv[16] = '{0, 1, 2, 8'hAA, 1, 2, 8'h12, 1, 0, 1, 4'hB, 8'h12, 1, 2};
    tv[17] = '{0, 1, 2, 8'hAA, 1, 3, 8'h13, 1, 0, 1, 4'h7, 8'h13, 1, 3};
    tv[18] = '{0, 1, 2, 8'hAA, 0, 0, 8'h00, 0, 0, 0, 4'hF, 8'h13, 1, 4};
    tv[19] = '{0, 1, 2, 8'hAA, 0, 0, 8'h00, 0, 0, 0, 4'hF, 8'h13, 1, 5};
    tv[20] = '{0, 1, 2, 8'hAA, 0, 0, 8'h00, 0, 1, 0, 4'hB, 8'hAA, 0, 5};
    tv[21] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4'hF, 8'hAA, 0, 5};

    model_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      set_in(tv[i].rst, tv[i].pav, tv[i].pas, tv[i].pad, tv[i].pbv, tv[i].pbs, tv[i].pbd, tv[i].lk);
      cycle(0);
      chk($sformatf("vec%0d.pa_ready", i), s_ra, tv[i].ra);
      chk($sformatf("vec%0d.pb_ready", i), s_rb, tv[i].rb);
      chk($sformatf("vec%0d.load_n", i),   b4.reg_load_n, tv[i].ln);
      chk($sformatf("vec%0d.bus_out", i),  b4.bus_out,    tv[i].bus);
      chk($sformatf("vec%0d.owner", i),    b4.bus_owner,  tv[i].own);
      chk($sformatf("vec%0d.stall", i),    b4.stall_cnt,  tv[i].stall);
    end

    // Out-of-range select on the 3-register build.
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle(0);
    set_in(0, 1, 3, 8'h77, 0, 0, 0, 0); cycle(0);
    chk("oor.load_n3", b3.reg_load_n, 3'h7);
    chk("oor.sel_err3", b3.sel_err, 1);
    chk("oor.bus_out3", b3.bus_out, 8'h77);
    chk("oor.load_n4", b4.reg_load_n, 4'h7);
    chk("oor.sel_err4", b4.sel_err, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle(0);
    chk("oor.pulse_end", b3.sel_err, 0);
    chk("oor.load_n3_idle", b3.reg_load_n, 3'h7);

    // Reset asserted while a strobe is active.
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle(0);
    set_in(0, 1, 0, 8'h44, 0, 0, 0, 0); cycle(0);
    chk("rstdrv.strobe", b4.reg_load_n, 4'hE);
    set_in(1, 1, 1, 8'h45, 1, 2, 8'h46, 0); cycle(0);
    chk("rstdrv.pa_ready", s_ra, 0);
    chk("rstdrv.pb_ready", s_rb, 0);
    chk("rstdrv.load_n", b4.reg_load_n, 4'hF);
    chk("rstdrv.bus_out", b4.bus_out, 8'h00);
    set_in(0, 1, 1, 8'h45, 1, 2, 8'h46, 0); cycle(0);
    chk("rstdrv.a_wins", s_ra, 1);
    chk("rstdrv.b_waits", s_rb, 0);
    chk("rstdrv.load_n_after", b4.reg_load_n, 4'hD);

    // Stall counter saturation: A starved under a long B lock.
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle(0);
    set_in(0, 0, 0, 0, 1, 0, 8'h01, 1); cycle(0);
    a_seen = 0;
    for (int i = 0; i < 300; i++) begin
      set_in(0, 1, 1, 8'h99, 1, 2'($urandom), 8'($urandom), 1);
      cycle(0);
      if (s_ra === 1'b1) a_seen = 1;
    end
    chk("sat.stall", b4.stall_cnt, 8'hFF);
    chk("sat.a_starved", a_seen, 0);
    cycle(0);
    chk("sat.hold", b4.stall_cnt, 8'hFF);

    // Randomized run against the reference model.
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle(0);
    for (int n = 0; n < 1500; n++) begin
      set_in($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 6, 2'($urandom), 8'($urandom),
             $urandom_range(0, 9) < 6, 2'($urandom), 8'($urandom), $urandom_range(0, 1) == 1);
      cycle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
